// File: rtl/bpsk_word_serializer.sv
`default_nettype none
// ============================================================================
// Module   : bpsk_word_serializer
// Purpose  : Takes words delivered by the clock-domain synchronizer (data word
//            plus 1-cycle valid pulse) and serialises them into BPSK symbols,
//            one bit per SYM_DIV clocks. Provides a symbol strobe, the raw
//            bit and the carrier phase select (optionally differentially
//            encoded). One word shifts while a second is held, so
//            back-to-back words go out with no gap.
// Ports    : clk      modulator clock
//            rst_n    asynchronous active-low reset
//            w        word-valid pulse (1 cycle)
//            I        word, sampled only while w=1
//            ovf_clr  clears the sticky overflow flag
//            ready    1 when the holding buffer is free
//            bit_out  data bit of the current symbol
//            phase    carrier phase select (0 = 0deg, 1 = 180deg)
//            sym_stb  1-cycle pulse on the first cycle of each symbol
//            busy     1 while a word is being shifted out
//            ovf      sticky: a word was dropped
// Revision : 1.0  initial release
// ============================================================================
module bpsk_word_serializer #(
    parameter int WIDTH     = 16,
    parameter int SYM_DIV   = 8,
    parameter int MSB_FIRST = 1,
    parameter int DIFF      = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             w,
    input  logic [WIDTH-1:0] I,
    input  logic             ovf_clr,
    output logic             ready,
    output logic             bit_out,
    output logic             phase,
    output logic             sym_stb,
    output logic             busy,
    output logic             ovf
);

    localparam int c_DIV_W = (SYM_DIV > 2) ? $clog2(SYM_DIV) : 1;
    localparam int c_CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    localparam logic [c_DIV_W-1:0] c_DIV_LAST = c_DIV_W'(SYM_DIV - 1);
    localparam logic [c_CNT_W-1:0] c_BIT_LAST = c_CNT_W'(WIDTH - 1);

    localparam logic [0:0] c_ST_IDLE  = 1'b0;
    localparam logic [0:0] c_ST_SHIFT = 1'b1;

    logic [0:0]         r_state;
    logic [WIDTH-1:0]   r_hold;
    logic               r_hold_v;
    logic [WIDTH-1:0]   r_shreg;
    logic [c_DIV_W-1:0] r_div_cnt;
    logic [c_CNT_W-1:0] r_bit_cnt;
    logic               r_bit_out;
    logic               r_phase;
    logic               r_sym_stb;
    logic               r_ovf;

    logic               w_in_shift;
    logic               w_sym_end;
    logic               w_word_end;
    logic               w_advance;
    logic               w_load;
    logic               w_hold_take;
    logic               w_drop;
    logic [WIDTH-1:0]   w_src;
    logic               w_first_bit;
    logic [WIDTH-1:0]   w_load_shreg;
    logic               w_next_bit;
    logic [WIDTH-1:0]   w_shifted;
    logic               w_new_bit;

    assign w_in_shift = (r_state == c_ST_SHIFT);
    assign w_sym_end  = w_in_shift && (r_div_cnt == c_DIV_LAST);
    assign w_word_end = w_sym_end && (r_bit_cnt == c_BIT_LAST);
    assign w_advance  = w_sym_end && !w_word_end;

    // A new word starts from IDLE, or seamlessly at the last cycle of the
    // previous word, whenever a source (held word or incoming word) exists.
    assign w_load = (r_hold_v | w) && (!w_in_shift || w_word_end);

    // The held word takes priority; an incoming word only goes straight to
    // the shifter when nothing is held.
    assign w_src = r_hold_v ? r_hold : I;

    // Incoming word goes to the holding buffer when the buffer is free and
    // the word is not itself being loaded directly, or when the buffer is
    // emptied by a load on this very edge.
    assign w_hold_take = w && (r_hold_v ? w_load : !w_load);
    assign w_drop      = w && r_hold_v && !w_load;

    // The shift register holds the bits still to be sent, with the next one
    // always sitting at the output end; the current bit lives in r_bit_out.
    generate
        if (MSB_FIRST != 0) begin : g_msb_first
            assign w_first_bit  = w_src[WIDTH-1];
            assign w_load_shreg = {w_src[WIDTH-2:0], 1'b0};
            assign w_next_bit   = r_shreg[WIDTH-1];
            assign w_shifted    = {r_shreg[WIDTH-2:0], 1'b0};
        end else begin : g_lsb_first
            assign w_first_bit  = w_src[0];
            assign w_load_shreg = {1'b0, w_src[WIDTH-1:1]};
            assign w_next_bit   = r_shreg[0];
            assign w_shifted    = {1'b0, r_shreg[WIDTH-1:1]};
        end
    endgenerate

    assign w_new_bit = w_load ? w_first_bit : w_next_bit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= c_ST_IDLE;
            r_hold    <= '0;
            r_hold_v  <= 1'b0;
            r_shreg   <= '0;
            r_div_cnt <= '0;
            r_bit_cnt <= '0;
            r_bit_out <= 1'b0;
            r_phase   <= 1'b0;
            r_sym_stb <= 1'b0;
            r_ovf     <= 1'b0;
        end else begin
            r_sym_stb <= w_load | w_advance;

            if (w_load) begin
                r_state   <= c_ST_SHIFT;
                r_shreg   <= w_load_shreg;
                r_bit_cnt <= '0;
                r_div_cnt <= '0;
            end else if (w_advance) begin
                r_shreg   <= w_shifted;
                r_bit_cnt <= r_bit_cnt + c_CNT_W'(1);
                r_div_cnt <= '0;
            end else if (w_word_end) begin
                r_state   <= c_ST_IDLE;
                r_div_cnt <= '0;
            end else if (w_in_shift) begin
                r_div_cnt <= r_div_cnt + c_DIV_W'(1);
            end

            // Bit and phase change only on symbol starts; they hold their
            // value through idle gaps.
            if (w_load || w_advance) begin
                r_bit_out <= w_new_bit;
                r_phase   <= (DIFF != 0) ? (r_phase ^ w_new_bit) : w_new_bit;
            end

            if (w_hold_take) begin
                r_hold   <= I;
                r_hold_v <= 1'b1;
            end else if (w_load && r_hold_v) begin
                r_hold_v <= 1'b0;
            end

            // A drop on the same edge as a clear leaves the flag set.
            if (w_drop) begin
                r_ovf <= 1'b1;
            end else if (ovf_clr) begin
                r_ovf <= 1'b0;
            end
        end
    end

    assign ready   = ~r_hold_v;
    assign bit_out = r_bit_out;
    assign phase   = r_phase;
    assign sym_stb = r_sym_stb;
    assign busy    = r_state[0];
    assign ovf     = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_bpsk_word_serializer.sv
`default_nettype none
// ============================================================================
// Module   : tb_bpsk_word_serializer
// Purpose  : Self-checking bench for bpsk_word_serializer. Three instances
//            with different SYM_DIV / MSB_FIRST / DIFF settings share one
//            stimulus stream; each is compared every cycle against a
//            word-level reference model (pending-word count, elapsed time
//            within the word, bit index = time / SYM_DIV).
// Revision : 1.0  initial release
// ============================================================================
module tb_bpsk_word_serializer;

    logic        clk;
    logic        rst_n;
    logic        w;
    logic [15:0] I;
    logic        ovf_clr;

    logic d_ready[3];
    logic d_bit[3];
    logic d_phase[3];
    logic d_stb[3];
    logic d_busy[3];
    logic d_ovf[3];

    int n_tests;
    int n_fail;

    bpsk_word_serializer #(.WIDTH(16), .SYM_DIV(4), .MSB_FIRST(1), .DIFF(0)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .w(w), .I(I), .ovf_clr(ovf_clr),
        .ready(d_ready[0]), .bit_out(d_bit[0]), .phase(d_phase[0]),
        .sym_stb(d_stb[0]), .busy(d_busy[0]), .ovf(d_ovf[0]));

    bpsk_word_serializer #(.WIDTH(16), .SYM_DIV(4), .MSB_FIRST(1), .DIFF(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .w(w), .I(I), .ovf_clr(ovf_clr),
        .ready(d_ready[1]), .bit_out(d_bit[1]), .phase(d_phase[1]),
        .sym_stb(d_stb[1]), .busy(d_busy[1]), .ovf(d_ovf[1]));

    bpsk_word_serializer #(.WIDTH(16), .SYM_DIV(2), .MSB_FIRST(0), .DIFF(0)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .w(w), .I(I), .ovf_clr(ovf_clr),
        .ready(d_ready[2]), .bit_out(d_bit[2]), .phase(d_phase[2]),
        .sym_stb(d_stb[2]), .busy(d_busy[2]), .ovf(d_ovf[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int div_of(input int i);
        return (i == 2) ? 2 : 4;
    endfunction

    function automatic bit msb_of(input int i);
        return (i != 2);
    endfunction

    function automatic bit diff_of(input int i);
        return (i == 1);
    endfunction

    task automatic check(input string tag, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got %0d expected %0d", tag, $time, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    bit          m_act[3];
    logic [15:0] m_word[3];
    int          m_t[3];
    int          m_pn[3];
    logic [15:0] m_pw[3];
    bit          m_bit[3];
    bit          m_ph[3];
    bit          m_stb[3];
    bit          m_ovf[3];

    task automatic model_step(input int i);
        int dv;
        int k;
        bit drop;
        bit nb;
        dv   = div_of(i);
        drop = 1'b0;
        if (!m_act[i] || m_t[i] == 16 * dv - 1) begin
            if (m_pn[i] != 0) begin
                m_word[i] = m_pw[i];
                m_pn[i]   = 0;
                m_act[i]  = 1'b1;
                m_t[i]    = 0;
                if (w) begin
                    m_pw[i] = I;
                    m_pn[i] = 1;
                end
            end else if (w) begin
                m_word[i] = I;
                m_act[i]  = 1'b1;
                m_t[i]    = 0;
            end else begin
                m_act[i] = 1'b0;
            end
        end else begin
            m_t[i]++;
            if (w) begin
                if (m_pn[i] == 0) begin
                    m_pw[i] = I;
                    m_pn[i] = 1;
                end else begin
                    drop = 1'b1;
                end
            end
        end
        if (drop) m_ovf[i] = 1'b1;
        else if (ovf_clr) m_ovf[i] = 1'b0;
        m_stb[i] = 1'b0;
        if (m_act[i] && (m_t[i] % dv) == 0) begin
            k  = m_t[i] / dv;
            nb = msb_of(i) ? m_word[i][15-k] : m_word[i][k];
            m_stb[i] = 1'b1;
            m_bit[i] = nb;
            m_ph[i]  = diff_of(i) ? (m_ph[i] ^ nb) : nb;
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 3; i++) begin
                m_act[i] = 1'b0; m_word[i] = '0; m_t[i] = 0; m_pn[i] = 0;
                m_pw[i] = '0; m_bit[i] = 1'b0; m_ph[i] = 1'b0;
                m_stb[i] = 1'b0; m_ovf[i] = 1'b0;
            end
        end else begin
            for (int i = 0; i < 3; i++) model_step(i);
        end
    end

    // ---------------- comparison on the inactive edge ----------------
    bit cnt_en;
    int stb_cnt;
    int busy_cnt;

    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            check($sformatf("u%0d.ready", i),   int'(d_ready[i]), int'(m_pn[i] == 0));
            check($sformatf("u%0d.bit_out", i), int'(d_bit[i]),   int'(m_bit[i]));
            check($sformatf("u%0d.phase", i),   int'(d_phase[i]), int'(m_ph[i]));
            check($sformatf("u%0d.sym_stb", i), int'(d_stb[i]),   int'(m_stb[i]));
            check($sformatf("u%0d.busy", i),    int'(d_busy[i]),  int'(m_act[i]));
            check($sformatf("u%0d.ovf", i),     int'(d_ovf[i]),   int'(m_ovf[i]));
        end
        if (cnt_en) begin
            stb_cnt  += int'(d_stb[0]);
            busy_cnt += int'(d_busy[0]);
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input logic [15:0] data);
        w = 1'b1;
        I = data;
        tick(1);
        w = 1'b0;
        I = 16'($urandom);
    endtask

    initial begin
        n_tests = 0; n_fail = 0;
        cnt_en = 1'b0; stb_cnt = 0; busy_cnt = 0;
        w = 1'b0; I = '0; ovf_clr = 1'b0; rst_n = 1'b0;
        tick(3);
        rst_n = 1'b1;
        tick(2);

        // single word, count strobes and busy cycles of the SYM_DIV=4 unit
        cnt_en = 1'b1;
        send(16'hA5C3);
        tick(80);
        cnt_en = 1'b0;
        check("t1.stb_count", stb_cnt, 16);
        check("t1.busy_cycles", busy_cnt, 64);

        // back-to-back words
        send(16'hA5C3);
        tick(9);
        send(16'hFFFF);
        tick(140);

        // overflow and clear
        send(16'h1111);
        tick(5);
        send(16'h2222);
        tick(5);
        send(16'h3333);
        tick(5);
        ovf_clr = 1'b1;
        tick(1);
        ovf_clr = 1'b0;
        tick(5);
        ovf_clr = 1'b1;
        send(16'h4444);
        ovf_clr = 1'b0;
        tick(150);

        // differential encoding pattern
        send(16'h8001);
        tick(80);

        // reset during bit 7, with a word pulse while held in reset
        send(16'h1234);
        tick(4 * 7 + 1);
        rst_n = 1'b0;
        w = 1'b1;
        I = 16'hBEEF;
        tick(1);
        w = 1'b0;
        tick(1);
        rst_n = 1'b1;
        tick(1);
        send(16'h0F0F);
        tick(80);

        // LSB-first single bit
        send(16'h0001);
        tick(80);

        // randomized traffic with an occasional reset
        for (int c = 0; c < 3000; c++) begin
            w       = ($urandom_range(0, 24) == 0);
            I       = 16'($urandom);
            ovf_clr = ($urandom_range(0, 15) == 0);
            rst_n   = !(c >= 1500 && c < 1502);
            tick(1);
        end
        w = 1'b0;
        ovf_clr = 1'b0;
        rst_n = 1'b1;
        tick(150);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
